muldiv_hilo_unit: RTL and testbench
===================================

// Module: muldiv_hilo_unit
// PURPOSE
//  Parametrised multi-cycle integer multiply/divide unit owning the HI/LO register pair.
//  Sits beside the EX-stage ALU and replaces the single-cycle HI/LO path.
//  Interlocks the pipeline: stalls HI/LO reads and new requests while an operation is in flight.
// PARAMETERS
//  XLEN     32  operand / HI / LO width
//  MUL_LAT  3   multiply latency in cycles, >=1 (pipelined product, registered result)
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       EX presents an op
//  req_ready  out  1       unit idle and able to accept (=state IDLE & ~flush)
//  op         in   3       muldiv_pkg::op_t
//  in_a       in   XLEN    rs value / dividend / MT source
//  in_b       in   XLEN    rt value / divisor
//  flush      in   1       branch/jump flush of the op in flight
//  rd_req     in   1       EX needs HI/LO this cycle (MFHI/MFLO)
//  rd_sel     in   1       0=LO, 1=HI
//  rd_data    out  XLEN    selected HI/LO, combinational
//  hilo_stall out  1       rd_req & busy; core holds PC/IFID/IDEX
//  busy       out  1       state != IDLE
//  done       out  1       one-cycle pulse: HI/LO hold the new result this cycle
//  div_zero   out  1       with done: last DIV/DIVU had in_b==0
// BEHAVIOUR
//  - Reset: HI=LO=0, state IDLE, busy=done=div_zero=hilo_stall=0, req_ready=1.
//  - Accept when req_valid & req_ready (cycle T). Operands captured at T.
//  - States IDLE -> MUL (countdown MUL_LAT-1) | DIV (XLEN iterations) | WB -> IDLE.
//  - Latency L (done=1 and HI/LO new in cycle T+L): MTHI/MTLO L=1; MULT/MULTU L=MUL_LAT;
//    DIV/DIVU L=XLEN+1; divide by zero L=1.
//  - MULT: {HI,LO}=2*XLEN product; MULTU unsigned. DIV: LO=quotient, HI=remainder,
//    truncation toward zero, remainder takes dividend sign.
//  - Divide by zero: LO=all ones, HI=in_a, div_zero=1.
//  - Signed MIN / -1: LO=MIN, HI=0, no flag.
//  - MTHI/MTLO write only the named half; the other half is unchanged.
//  - flush while busy: op aborted, HI/LO unchanged, no done, IDLE next cycle.
//  - flush in the accept cycle: the request is not accepted.
//  - req_valid while busy: ignored (no queue). EX holds the op, guaranteed by the stall.
//  - rd_req in cycle T+L reads the new value (done cycle, busy=0). HI/LO update at the
//    edge ending cycle T+L-1.
//  - rst mid-operation: immediate abort; reset values apply the next cycle.
//  - Op codes 6/7 without MULDIV_ACC_EN: accepted, done after 1 cycle, HI/LO unchanged.
// CONFIGURATION
//  MULDIV_ACC_EN defined: MADD(6)/MSUB(7) are supported as {HI,LO} +/- signed in_a*in_b,
//    modulo 2^(2*XLEN), L=MUL_LAT+1 (extra accumulate cycle).
//  Not defined: no accumulator adder; ops 6/7 act as NOPs as above.
// STRUCTURE
//  - muldiv_pkg: op_t {MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MADD=6, MSUB=7};
//    state_t {IDLE, MUL, DIV, WB}; DIV_CNT_W=$clog2(XLEN+1).
//  - Sub-module muldiv_divider: iterative restoring divider on magnitudes; start/flush in,
//    quotient/remainder/valid out. Sign fix-up is done in the parent in cycle T+XLEN.
//  - Multiplier: inline, MUL_LAT-stage register chain on the product.
// TESTING
//  - MULT 0xFFFFFFFE * 3 (XLEN=32, MUL_LAT=3) -> done at T+3, HI=0xFFFFFFFF, LO=0xFFFFFFFA;
//    MULTU -> HI=0x2, LO=0xFFFFFFFA.
//  - DIV -7/2 -> done at T+33, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
//  - DIV 5/0 -> done and div_zero at T+1, LO=0xFFFFFFFF, HI=5; DIV 0x80000000/-1 ->
//    LO=0x80000000, HI=0.
//  - MFLO (rd_req) issued at T+1 of a DIV -> hilo_stall=1 through T+32, 0 at T+33 with
//    rd_data=quotient; req_ready=0 throughout.
//  - flush at T+10 of DIV after MTLO 0x1234 -> no done, busy=0 at T+11, LO stays 0x1234;
//    rst at T+5 -> HI=LO=0 next cycle.
//  - MULDIV_ACC_EN: HI=0, LO=10, MADD 3*4 -> LO=22 at T+4; MSUB 5*5 -> {HI,LO}=-3.
//    Without the macro, op 6 -> done at T+1, LO stays 10.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation codes, FSM states
// and the divider counter width helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  localparam int XLEN_DEFAULT = 32;
  localparam int DIV_CNT_W    = $clog2(XLEN_DEFAULT + 1);

  // Iteration counter width for an XLEN-bit divider.
  function automatic int div_cnt_w(input int xlen);
    return $clog2(xlen + 1);
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// EX-stage <-> HI/LO unit bundle: request handshake, flush, HI/LO read port
// and status. master = pipeline core side, slave = muldiv_hilo_unit.
interface muldiv_hilo_unit_if #(
  parameter int XLEN = 32
);
  import muldiv_pkg::*;

  logic            req_valid;
  logic            req_ready;
  op_t             op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            flush;
  logic            rd_req;
  logic            rd_sel;
  logic [XLEN-1:0] rd_data;
  logic            hilo_stall;
  logic            busy;
  logic            done;
  logic            div_zero;

  modport master (
    output req_valid, op, in_a, in_b, flush, rd_req, rd_sel,
    input  req_ready, rd_data, hilo_stall, busy, done, div_zero
  );

  modport slave (
    input  req_valid, op, in_a, in_b, flush, rd_req, rd_sel,
    output req_ready, rd_data, hilo_stall, busy, done, div_zero
  );

endinterface

// File: rtl/muldiv_divider.sv
// Iterative restoring divider on unsigned magnitudes. The first iteration is
// folded into the start cycle so the XLEN-th quotient bit is registered at the
// edge ending cycle T+XLEN-1; o_valid pulses in cycle T+XLEN.
module muldiv_divider
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder,
  output logic            o_valid
);

  localparam int CW = div_cnt_w(XLEN);

  logic [XLEN-1:0] r_rem, r_quo, r_div;
  logic [CW-1:0]   r_cnt;
  logic            r_active, r_valid;
  logic [XLEN-1:0] w_rem_in, w_quo_in, w_div_in, w_rem_nxt, w_quo_nxt;
  logic [XLEN:0]   w_trial;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    w_rem_in  = i_start ? '0 : r_rem;
    w_quo_in  = i_start ? i_dividend : r_quo;
    w_div_in  = i_start ? i_divisor : r_div;
    w_trial   = {w_rem_in, w_quo_in[XLEN-1]} - {1'b0, w_div_in};
    w_rem_nxt = {w_rem_in[XLEN-2:0], w_quo_in[XLEN-1]};
    w_quo_nxt = {w_quo_in[XLEN-2:0], 1'b0};
    if (!w_trial[XLEN]) begin
      w_rem_nxt = w_trial[XLEN-1:0];
      w_quo_nxt = {w_quo_in[XLEN-2:0], 1'b1};
    end
  end

  // Datapath registers advance on start and on every active cycle.
  always_ff @(posedge clk) begin
    if (i_start || r_active) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
    end
    if (i_start) r_div <= i_divisor;
  end

  // Iteration control; flush drops the operation without a valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_valid  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_valid <= 1'b0;
      if (i_start) begin
        r_active <= (XLEN > 1);
        r_valid  <= (XLEN == 1);
        r_cnt    <= CW'(1);
      end else if (r_active) begin
        if (i_flush) begin
          r_active <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(XLEN - 1)) begin
            r_active <= 1'b0;
            r_valid  <= 1'b1;
          end
        end
      end
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;
  assign o_valid     = r_valid;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO, with pipeline interlock.
// Optional MADD/MSUB accumulate support is enabled by defining MULDIV_ACC_EN;
// without it ops 6/7 complete in one cycle and leave HI/LO untouched.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_hilo_unit_if.slave bus
);

  localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic              w_hi_we, w_lo_we;
  logic              r_done, w_done_nxt, r_div_zero, w_dz_nxt;
  logic [MCW-1:0]    r_mcnt, w_mcnt_nxt;
  logic              w_accept, w_div_start;
  logic              r_q_neg, r_r_neg;
  logic              w_mul_signed, w_div_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_div_q, w_div_r;
  logic              w_div_valid;
  logic signed [2*XLEN-1:0] w_a_ext, w_b_ext;
  logic [2*XLEN-1:0] w_prod_p0, w_prod_out;
`ifdef MULDIV_ACC_EN
  logic              r_acc_op, r_acc_sub, w_acc_ld;
  logic [2*XLEN-1:0] r_acc_p;
`endif

  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  assign bus.req_ready  = (r_state == ST_IDLE) & ~bus.flush;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.hilo_stall = bus.rd_req & bus.busy;
  assign bus.rd_data    = bus.rd_sel ? r_hi : r_lo;
  assign bus.done       = r_done;
  assign bus.div_zero   = r_div_zero;
  assign w_accept       = bus.req_valid & bus.req_ready;

  // Operand conditioning: sign/zero-extended multiplier inputs, divider magnitudes.
  always_comb begin
    w_mul_signed = (bus.op == OP_MULT) || (bus.op == OP_MADD) || (bus.op == OP_MSUB);
    w_div_signed = (bus.op == OP_DIV);
    w_a_ext      = $signed({{XLEN{w_mul_signed & bus.in_a[XLEN-1]}}, bus.in_a});
    w_b_ext      = $signed({{XLEN{w_mul_signed & bus.in_b[XLEN-1]}}, bus.in_b});
    w_prod_p0    = w_a_ext * w_b_ext;
    w_a_neg      = w_div_signed & bus.in_a[XLEN-1];
    w_b_neg      = w_div_signed & bus.in_b[XLEN-1];
    w_a_mag      = w_a_neg ? -bus.in_a : bus.in_a;
    w_b_mag      = w_b_neg ? -bus.in_b : bus.in_b;
  end

  generate
    if (MUL_LAT == 1) begin : g_mul_comb
      assign w_prod_out = w_prod_p0;
    end else begin : g_mul_pipe
      logic [2*XLEN-1:0] r_prod_p [MUL_LAT-1];
      // Product shift chain: slot k holds the product presented k+1 cycles ago.
      always_ff @(posedge clk) begin
        r_prod_p[0] <= w_prod_p0;
        for (int k = 1; k < MUL_LAT - 1; k++) r_prod_p[k] <= r_prod_p[k-1];
      end
      assign w_prod_out = r_prod_p[MUL_LAT-2];
    end
  endgenerate

  muldiv_divider #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_flush    (bus.flush),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_quotient (w_div_q),
    .o_remainder(w_div_r),
    .o_valid    (w_div_valid)
  );

  // Next-state, HI/LO write enables and done/div_zero pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_mcnt_nxt  = r_mcnt;
    w_hi_we     = 1'b0;
    w_lo_we     = 1'b0;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_done_nxt  = 1'b0;
    w_dz_nxt    = 1'b0;
    w_div_start = 1'b0;
`ifdef MULDIV_ACC_EN
    w_acc_ld    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (bus.op)
            OP_MTHI: begin
              w_hi_we = 1'b1; w_hi_nxt = bus.in_a; w_done_nxt = 1'b1;
            end
            OP_MTLO: begin
              w_lo_we = 1'b1; w_lo_nxt = bus.in_a; w_done_nxt = 1'b1;
            end
            OP_MULT, OP_MULTU: begin
              if (MUL_LAT == 1) begin
                w_hi_we = 1'b1; w_lo_we = 1'b1; w_done_nxt = 1'b1;
                {w_hi_nxt, w_lo_nxt} = w_prod_out;
              end else begin
                w_state_nxt = ST_MUL; w_mcnt_nxt = MCW'(MUL_LAT - 1);
              end
            end
            OP_DIV, OP_DIVU: begin
              if (bus.in_b == '0) begin
                w_hi_we = 1'b1; w_lo_we = 1'b1; w_done_nxt = 1'b1; w_dz_nxt = 1'b1;
                w_hi_nxt = bus.in_a; w_lo_nxt = '1;
              end else begin
                w_state_nxt = ST_DIV; w_div_start = 1'b1;
              end
            end
            default: begin
`ifdef MULDIV_ACC_EN
              if (MUL_LAT == 1) begin
                w_state_nxt = ST_WB; w_acc_ld = 1'b1;
              end else begin
                w_state_nxt = ST_MUL; w_mcnt_nxt = MCW'(MUL_LAT - 1);
              end
`else
              w_done_nxt = 1'b1;
`endif
            end
          endcase
        end
      end
      ST_MUL: begin
        if (bus.flush) begin
          w_state_nxt = ST_IDLE;
        end else if (r_mcnt == MCW'(1)) begin
          w_state_nxt = ST_IDLE;
          w_hi_we = 1'b1; w_lo_we = 1'b1; w_done_nxt = 1'b1;
          {w_hi_nxt, w_lo_nxt} = w_prod_out;
`ifdef MULDIV_ACC_EN
          if (r_acc_op) begin
            w_state_nxt = ST_WB; w_acc_ld = 1'b1;
            w_hi_we = 1'b0; w_lo_we = 1'b0; w_done_nxt = 1'b0;
          end
`endif
        end else begin
          w_mcnt_nxt = r_mcnt - MCW'(1);
        end
      end
      ST_DIV: begin
        if (bus.flush) begin
          w_state_nxt = ST_IDLE;
        end else if (w_div_valid) begin
          w_state_nxt = ST_IDLE;
          w_hi_we = 1'b1; w_lo_we = 1'b1; w_done_nxt = 1'b1;
          w_lo_nxt = neg_if(r_q_neg, w_div_q);
          w_hi_nxt = neg_if(r_r_neg, w_div_r);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
`ifdef MULDIV_ACC_EN
        if (!bus.flush) begin
          w_hi_we = 1'b1; w_lo_we = 1'b1; w_done_nxt = 1'b1;
          {w_hi_nxt, w_lo_nxt} = r_acc_sub ? ({r_hi, r_lo} - r_acc_p)
                                           : ({r_hi, r_lo} + r_acc_p);
        end
`endif
      end
    endcase
  end

  // FSM state, HI/LO and status pulses; HI/LO are architectural and reset too.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mcnt     <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mcnt     <= w_mcnt_nxt;
      r_done     <= w_done_nxt;
      r_div_zero <= w_dz_nxt;
      if (w_hi_we) r_hi <= w_hi_nxt;
      if (w_lo_we) r_lo <= w_lo_nxt;
    end
  end

  // Per-operation side information captured at accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_q_neg <= w_a_neg ^ w_b_neg;
      r_r_neg <= w_a_neg;
`ifdef MULDIV_ACC_EN
      r_acc_op  <= (bus.op == OP_MADD) || (bus.op == OP_MSUB);
      r_acc_sub <= (bus.op == OP_MSUB);
`endif
    end
`ifdef MULDIV_ACC_EN
    if (w_acc_ld) r_acc_p <= w_prod_out;
`endif
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: directed corner cases plus
// randomized operations against an arithmetic reference of HI/LO.
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 3;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_hilo_unit_if #(.XLEN(XLEN)) bus();

  muldiv_hilo_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: new HI/LO, div_zero flag and latency from the architectural rules.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] nhi, output logic [31:0] nlo,
                                output logic dz, output int lat);
    logic [63:0] p;
    int sa, sb;
    sa = a; sb = b;
    nhi = m_hi; nlo = m_lo; dz = 1'b0; lat = 1;
    case (op)
      3'd0: begin p = 64'(longint'(sa) * longint'(sb)); {nhi, nlo} = p; lat = MUL_LAT; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {nhi, nlo} = p; lat = MUL_LAT; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          nlo = 32'hFFFF_FFFF; nhi = a; dz = 1'b1; lat = 1;
        end else begin
          lat = XLEN + 1;
          if (op == 3'd3) begin
            nlo = a / b; nhi = a % b;
          end else if (a == MINV && b == 32'hFFFF_FFFF) begin
            nlo = MINV; nhi = 32'd0;
          end else begin
            nlo = sa / sb; nhi = sa % sb;
          end
        end
      end
      3'd4: nhi = a;
      3'd5: nlo = a;
      default: begin
`ifdef MULDIV_ACC_EN
        p = 64'(longint'(sa) * longint'(sb));
        {nhi, nlo} = (op == 3'd6) ? ({m_hi, m_lo} + p) : ({m_hi, m_lo} - p);
        lat = MUL_LAT + 1;
`else
        lat = 1;
`endif
      end
    endcase
  endfunction

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.rd_sel = 1'b0; #1 lo = bus.rd_data;
    bus.rd_sel = 1'b1; #1 hi = bus.rd_data;
    bus.rd_sel = 1'b0;
  endtask

  // Issue one op, wait for done, check latency, interlock, flag and HI/LO.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [31:0] ehi, elo, ghi, glo;
    logic edz;
    int lat_exp, lat, bad;
    model(op, a, b, ehi, elo, edz, lat_exp);
    @(negedge clk);
    bus.op = op_t'(op); bus.in_a = a; bus.in_b = b;
    bus.req_valid = 1'b1; bus.rd_req = 1'b1;
    #1 check({tag, ":ready"}, 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0; bad = 0;
    for (int k = 1; k <= 60; k++) begin
      if (bus.done) begin lat = k; break; end
      if (!bus.hilo_stall || bus.req_ready || !bus.busy) bad++;
      @(negedge clk);
    end
    check({tag, ":lat"}, 64'(lat), 64'(lat_exp));
    check({tag, ":interlock"}, 64'(bad), 64'd0);
    if (lat != 0) begin
      check({tag, ":done_idle"}, {62'd0, bus.busy, bus.hilo_stall}, 64'd0);
      check({tag, ":dz"}, 64'(bus.div_zero), 64'(edz));
      read_hilo(ghi, glo);
      check({tag, ":hilo"}, {ghi, glo}, {ehi, elo});
    end
    m_hi = ehi; m_lo = elo;
    bus.rd_req = 1'b0;
  endtask

  initial begin
    logic [31:0] ghi, glo, a, b;
    logic [2:0] op;
    int cnt;
    bus.req_valid = 1'b0; bus.op = OP_MULT; bus.in_a = '0; bus.in_b = '0;
    bus.flush = 1'b0; bus.rd_req = 1'b1; bus.rd_sel = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    read_hilo(ghi, glo);
    check("reset_hilo", {ghi, glo}, 64'd0);
    check("reset_status", {59'd0, bus.req_ready, bus.busy, bus.done, bus.div_zero, bus.hilo_stall},
          64'b10000);
    rst = 1'b0; bus.rd_req = 1'b0;
    m_hi = '0; m_lo = '0;

    // Directed arithmetic corners.
    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, "mult");
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, "multu");
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    do_op(3'd3, 32'd100, 32'd7, "divu");
    do_op(3'd2, 32'd5, 32'd0, "div_zero");
    do_op(3'd2, MINV, 32'hFFFF_FFFF, "div_min");
    do_op(3'd3, 32'hFFFF_FFFF, 32'd1, "divu_max");
    do_op(3'd4, 32'hA5A5_0001, 32'd0, "mthi");
    do_op(3'd5, 32'h1234, 32'd0, "mtlo");

    // Flush of a divide in flight at T+10.
    @(negedge clk);
    bus.op = OP_DIV; bus.in_a = 32'd100; bus.in_b = 32'd3; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", {62'd0, bus.busy, bus.done}, 64'd0);
    read_hilo(ghi, glo);
    check("flush_hilo", {ghi, glo}, {m_hi, m_lo});
    cnt = 0;
    repeat (40) begin @(negedge clk); if (bus.done) cnt++; end
    check("flush_nodone", 64'(cnt), 64'd0);

    // Flush in the accept cycle blocks the request.
    bus.op = OP_MTLO; bus.in_a = 32'hDEAD; bus.req_valid = 1'b1; bus.flush = 1'b1;
    #1 check("flush_accept_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    check("flush_accept", {62'd0, bus.busy, bus.done}, 64'd0);
    read_hilo(ghi, glo);
    check("flush_accept_hilo", {ghi, glo}, {m_hi, m_lo});

    // Accumulate ops (NOPs unless the accumulator is built in).
    do_op(3'd4, 32'd0, 32'd0, "acc_hi0");
    do_op(3'd5, 32'd10, 32'd0, "acc_lo10");
    do_op(3'd6, 32'd3, 32'd4, "madd");
    do_op(3'd7, 32'd5, 32'd5, "msub");

    // Reset in the middle of a divide.
    do_op(3'd4, 32'h55, 32'd0, "pre_rst");
    @(negedge clk);
    bus.op = OP_DIV; bus.in_a = 32'd100; bus.in_b = 32'd3; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    check("rst_mid_busy", {62'd0, bus.busy, bus.done}, 64'd0);
    read_hilo(ghi, glo);
    check("rst_mid_hilo", {ghi, glo}, 64'd0);
    cnt = 0;
    repeat (40) begin @(negedge clk); if (bus.done) cnt++; end
    check("rst_mid_nodone", 64'(cnt), 64'd0);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = MINV; b = 32'hFFFF_FFFF; end
        2, 3: begin
          a = $urandom_range(0, 50); b = $urandom_range(1, 9);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: ;
      endcase
      do_op(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
